// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared single-precision field widths, constants, flag indices and operand classes
package fp_pkg;

    localparam int DATA_W = 32;
    localparam int EXP_W  = 8;
    localparam int MANT_W = 23;
    localparam int BIAS   = 127;
    localparam int FLAG_W = 5;

    localparam logic [DATA_W-1:0] QNAN_WORD = 32'h7FC00000;
    localparam logic [EXP_W-1:0]  EXP_ONES  = 8'hFF;
    localparam logic [EXP_W-1:0]  EXP_ZERO  = 8'h00;

    localparam int FLG_INVALID = 4;
    localparam int FLG_OVF     = 3;
    localparam int FLG_UNF     = 2;
    localparam int FLG_INF     = 1;
    localparam int FLG_ZERO    = 0;

    typedef enum logic [1:0] {
        CLS_NORM = 2'd0,
        CLS_ZERO = 2'd1,
        CLS_INF  = 2'd2,
        CLS_NAN  = 2'd3
    } op_class_e;

    // Denormals (exp==0) are treated as zero; width-agnostic so any format can use it
    function automatic op_class_e classify(input logic exp_zero, input logic exp_ones,
                                           input logic mant_nz);
        op_class_e cls;
        cls = CLS_NORM;
        if (exp_zero)
            cls = CLS_ZERO;
        else if (exp_ones)
            cls = mant_nz ? CLS_NAN : CLS_INF;
        return cls;
    endfunction

endpackage

// File: rtl/fp_mul_fixup.sv
// rtl/fp_mul_fixup.sv - combinational special-case fix-up of a raw multiplier product
module fp_mul_fixup
    import fp_pkg::*;
#(
    parameter int                    DATA_WIDTH = DATA_W,
    parameter int                    EXP_WIDTH  = EXP_W,
    parameter int                    MANT_WIDTH = MANT_W,
    parameter logic [DATA_WIDTH-1:0] QNAN       = QNAN_WORD
) (
    input  logic [DATA_WIDTH-1:0] i_num_a,
    input  logic [DATA_WIDTH-1:0] i_num_b,
    input  logic [DATA_WIDTH-1:0] i_result,
    output logic [DATA_WIDTH-1:0] o_result,
    output logic [FLAG_W-1:0]     o_flags
);

    localparam int SUM_W = EXP_WIDTH + 2;
    localparam int EBIAS = (1 << (EXP_WIDTH - 1)) - 1;
    localparam int EMAX  = (1 << EXP_WIDTH) - 1;

    logic [EXP_WIDTH-1:0]    w_exp_a;
    logic [EXP_WIDTH-1:0]    w_exp_b;
    logic [EXP_WIDTH-1:0]    w_exp_r;
    op_class_e               w_cls_a;
    op_class_e               w_cls_b;
    logic                    w_sign;
    logic signed [SUM_W-1:0] w_esum;
    logic                    w_unused_raw_sign;

    assign w_exp_a = i_num_a[DATA_WIDTH-2 -: EXP_WIDTH];
    assign w_exp_b = i_num_b[DATA_WIDTH-2 -: EXP_WIDTH];
    assign w_exp_r = i_result[DATA_WIDTH-2 -: EXP_WIDTH];

    // The multiplier's sign is ignored; the sign is always recomputed from the operands
    assign w_unused_raw_sign = i_result[DATA_WIDTH-1];

    assign w_cls_a = classify(~|w_exp_a, &w_exp_a, |i_num_a[MANT_WIDTH-1:0]);
    assign w_cls_b = classify(~|w_exp_b, &w_exp_b, |i_num_b[MANT_WIDTH-1:0]);
    assign w_sign  = i_num_a[DATA_WIDTH-1] ^ i_num_b[DATA_WIDTH-1];

    // Two guard bits keep the biased sum signed and wide enough for 2*EMAX-EBIAS
    assign w_esum = $signed({2'b00, w_exp_a}) + $signed({2'b00, w_exp_b})
                  - $signed(SUM_W'(EBIAS));

    // Priority-ordered special-case selection; the mantissa is never rounded
    always_comb begin
        o_result = '0;
        o_flags  = '0;
        if (w_cls_a == CLS_NAN || w_cls_b == CLS_NAN ||
            (w_cls_a == CLS_INF && w_cls_b == CLS_ZERO) ||
            (w_cls_a == CLS_ZERO && w_cls_b == CLS_INF)) begin
            o_result             = QNAN;
            o_flags[FLG_INVALID] = 1'b1;
        end else if (w_cls_a == CLS_INF || w_cls_b == CLS_INF) begin
            o_result         = {w_sign, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
            o_flags[FLG_INF] = 1'b1;
        end else if (w_cls_a == CLS_ZERO || w_cls_b == CLS_ZERO) begin
            o_result          = {w_sign, {EXP_WIDTH{1'b0}}, {MANT_WIDTH{1'b0}}};
            o_flags[FLG_ZERO] = 1'b1;
        end else if (w_esum >= $signed(SUM_W'(EMAX)) ||
                     (w_esum == $signed(SUM_W'(EMAX - 1)) && (&w_exp_r))) begin
            o_result         = {w_sign, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
            o_flags[FLG_OVF] = 1'b1;
            o_flags[FLG_INF] = 1'b1;
        end else if (w_esum <= $signed(SUM_W'(0))) begin
            o_result          = {w_sign, {EXP_WIDTH{1'b0}}, {MANT_WIDTH{1'b0}}};
            o_flags[FLG_UNF]  = 1'b1;
            o_flags[FLG_ZERO] = 1'b1;
        end else begin
            o_result = {w_sign, i_result[DATA_WIDTH-2:0]};
        end
    end

endmodule

// File: rtl/fp_mul_post.sv
// rtl/fp_mul_post.sv - registered multiplier post-stage with 2-entry skid buffer and sticky flags
module fp_mul_post
    import fp_pkg::*;
#(
    parameter int                    DATA_WIDTH = DATA_W,
    parameter int                    EXP_WIDTH  = EXP_W,
    parameter int                    MANT_WIDTH = MANT_W,
    parameter logic [DATA_WIDTH-1:0] QNAN       = QNAN_WORD
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_numA,
    input  logic [DATA_WIDTH-1:0] in_numB,
    input  logic [DATA_WIDTH-1:0] in_result,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_result,
    output logic [FLAG_W-1:0]     out_flags,
    input  logic                  in_flag_clr,
    output logic [FLAG_W-1:0]     out_sticky
);

    localparam int ENT_W = FLAG_W + DATA_WIDTH;

    logic [DATA_WIDTH-1:0] w_fix_result;
    logic [FLAG_W-1:0]     w_fix_flags;
    logic [ENT_W-1:0]      w_new_ent;
    logic                  w_push;
    logic                  w_pop;
    logic [1:0]            w_count_nxt;

    logic [ENT_W-1:0]      r_ent0;
    logic [ENT_W-1:0]      r_ent1;
    logic [1:0]            r_count;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic [FLAG_W-1:0]     r_sticky;

    fp_mul_fixup #(
        .DATA_WIDTH (DATA_WIDTH),
        .EXP_WIDTH  (EXP_WIDTH),
        .MANT_WIDTH (MANT_WIDTH),
        .QNAN       (QNAN)
    ) u_fixup (
        .i_num_a  (in_numA),
        .i_num_b  (in_numB),
        .i_result (in_result),
        .o_result (w_fix_result),
        .o_flags  (w_fix_flags)
    );

    assign w_new_ent = {w_fix_flags, w_fix_result};
    assign w_push    = in_valid && r_in_ready;
    assign w_pop     = r_out_valid && out_ready;

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign out_result = r_ent0[DATA_WIDTH-1:0];
    assign out_flags  = r_ent0[ENT_W-1 -: FLAG_W];
    assign out_sticky = r_sticky;

    // Occupancy after this edge; drives the registered ready/valid
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 2'd1;
            2'b01:   w_count_nxt = r_count - 2'd1;
            default: w_count_nxt = r_count;
        endcase
    end

    // Skid buffer: entry 0 is always the head presented downstream
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ent0      <= '0;
            r_ent1      <= '0;
            r_count     <= 2'd0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_count     <= w_count_nxt;
            r_in_ready  <= (w_count_nxt != 2'd2);
            r_out_valid <= (w_count_nxt != 2'd0);
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0)
                        r_ent0 <= w_new_ent;
                    else
                        r_ent1 <= w_new_ent;
                end
                2'b01: begin
                    r_ent0 <= r_ent1;
                end
                2'b11: begin
                    if (r_count == 2'd2) begin
                        r_ent0 <= r_ent1;
                        r_ent1 <= w_new_ent;
                    end else begin
                        r_ent0 <= w_new_ent;
                    end
                end
                default: ;
            endcase
        end
    end

    // Sticky status: flags of a completing transfer win over a simultaneous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_sticky <= '0;
        else if (w_pop)
            r_sticky <= (in_flag_clr ? '0 : r_sticky) | out_flags;
        else if (in_flag_clr)
            r_sticky <= '0;
    end

endmodule

// File: doc/fp_mul_post.md
Name: fp_mul_post

Overview:
- Registered post-processing stage directly downstream of the combinational single-precision multiplier.
- Takes the multiplier's raw result together with the original operands. Fixes special cases (NaN, Inf, zero/denormal, exponent overflow/underflow) that the multiplier does not handle.
- Presents a clean IEEE-754 word through a valid/ready interface backed by a 2-entry skid buffer. Also keeps sticky exception flags for the FPU status register.

Parameters:
- DATA_WIDTH, 32, word width
- EXP_WIDTH, 8, exponent field width
- MANT_WIDTH, 23, mantissa field width
- QNAN, 32'h7FC00000, canonical NaN emitted on invalid operations

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  upstream result and operands valid
- in_ready  output  1  stage can accept this cycle
- in_numA  input  DATA_WIDTH  original operand A
- in_numB  input  DATA_WIDTH  original operand B
- in_result  input  DATA_WIDTH  raw multiplier output for A×B
- out_valid  output  1  out_result/out_flags valid
- out_ready  input  1  downstream accepts
- out_result  output  DATA_WIDTH  corrected product
- out_flags  output  5  per-result {invalid, overflow, underflow, inf, zero}
- in_flag_clr  input  1  clear sticky flags
- out_sticky  output  5  OR of out_flags over all completed output transfers since reset/clear

Behaviour:
- Clock and reset: one clock `clk`; `rst` is asynchronous and active-high.
- Reset values: out_valid=0, in_ready=1, out_result=0, out_flags=0, out_sticky=0, both skid entries empty.
- Classify each operand:
  - zero: exp==0 (denormals are flushed to zero)
  - inf: exp==FF, mant==0
  - nan: exp==FF, mant!=0
- Sign: s = A[31]^B[31].
- esum = eA+eB-127, computed as 10-bit signed.
- Fix-up, combinational, applied in priority order:
  1. Either operand nan, or inf×zero: result QNAN; invalid=1.
  2. Either operand inf: {s,FF,0}; inf=1.
  3. Either operand zero: {s,0,0}; zero=1.
  4. esum>=255, or (esum==254 and in_result[30:23]==FF): {s,FF,0}; overflow=1, inf=1.
  5. esum<=0: {s,0,0}; underflow=1, zero=1.
  6. Otherwise: {s, in_result[30:0]}, flags all 0.
- Input transfer: in_valid&&in_ready. The fixed-up word and flags are written into the skid buffer.
- Output transfer: out_valid&&out_ready.
- Skid buffer, 2 entries, FIFO order:
  - in_ready is registered: in_ready=0 exactly when both entries are occupied.
  - Empty stage, in transfer at edge N: out_valid=1 after edge N (latency 1 cycle).
  - Simultaneous in and out transfer: occupancy unchanged, order preserved. Full throughput is one result/cycle while out_ready=1.
  - out_ready=0 while out_valid=1: out_result and out_flags hold stable.
  - in_valid while in_ready=0: ignored; upstream holds.
- Sticky flags:
  - On each output transfer, out_sticky |= out_flags.
  - in_flag_clr alone: sticky cleared next edge.
  - in_flag_clr together with an output transfer: sticky = that transfer's out_flags (new flags win over clear).
- Reset mid-operation: buffered results are discarded, no output transfer occurs, sticky cleared.
- No rounding is performed; the mantissa passes through unchanged in case 6.

Decomposition:
- Shared fp_pkg:
  - field widths and bias 127
  - QNAN constant and FF/zero exponent constants
  - flag bit indices FLG_INVALID=4, FLG_OVF=3, FLG_UNF=2, FLG_INF=1, FLG_ZERO=0
  - operand-class encoding
- One sub-module, fp_mul_fixup: purely combinational classification and fix-up, producing result and flags.
- Top level holds the skid buffer, handshake and sticky register.

Test Plan:
- A=3FC00000, B=40000000, in_result=40400000, out_ready=1 → out_result=40400000 one cycle after transfer, flags=0.
- A=7F800000, B=00000000 → out_result=7FC00000, flags=10000. Then A=FF800000, B=40000000 → FF800000, flags=00010. out_sticky=10010 afterwards.
- A=7F000000, B=7F000000 (esum=381) → 7F800000, flags=01010. A=00800000, B=00800000 (esum=-125) → 00000000, flags=00101. A=80400000 (denormal), B=3F800000 → 80000000, flags=00001.
- Backpressure: out_ready=0, push 3 back-to-back valid inputs → in_ready falls after the 2nd accept, 3rd is held. Raise out_ready → all 3 emerge in order with no gap or duplicate.
- Sticky: in_flag_clr asserted in the same cycle as an output transfer carrying flags 01010 → out_sticky=01010. In_flag_clr alone → 00000.
- Assert rst with 2 entries buffered → out_valid=0 and in_ready=1 immediately, out_sticky=0. The first post-reset input appears after 1 cycle.
